// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the load/store bus master and its request FIFO.
package mem_bus_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  // Bank select is addr[11:10]
  localparam logic [1:0] BANK_INSTR = 2'b00;
  localparam logic [1:0] BANK_DATA1 = 2'b01;
  localparam logic [1:0] BANK_DATA2 = 2'b10;
  localparam logic [1:0] BANK_DATA3 = 2'b11;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RD_ADDR = 2'd2,
    ST_RD_DATA = 2'd3
  } state_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit to tell full from empty.
module req_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  mem_req_t push_data,
  input  logic     pop,
  output mem_req_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  mem_req_t    entries [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = entries[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mem_bus_controller.sv
// Load/store bus master: queues CPU word requests and sequences them one at a time
// onto the banked memory port, returning in-order responses.
module mem_bus_controller #(
  parameter int QUEUE_DEPTH = 2,
  parameter int ADDR_W      = mem_bus_pkg::ADDR_W,
  parameter int DATA_W      = mem_bus_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_address_bus,
  inout  wire  [DATA_W-1:0] mem_data_bus,
  output logic              mem_write_mode,
  output logic              busy
);
  import mem_bus_pkg::*;

  state_t            state;
  mem_req_t          push_req, head;
  logic              fifo_full, fifo_empty, push, pop;
  logic [DATA_W-1:0] wdata_q;

  assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = !fifo_empty || (state != ST_IDLE);

  req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Drive enable is the write_mode register itself, so the memory and the
  // controller can never own the bus in the same cycle.
  assign mem_data_bus = mem_write_mode ? wdata_q : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      mem_write_mode  <= 1'b0;
      mem_address_bus <= '0;
      wdata_q         <= '0;
      rsp_valid       <= 1'b0;
      rsp_write       <= 1'b0;
      rsp_err         <= 1'b0;
      rsp_rdata       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head.addr[0]) begin
              // Misaligned: answer immediately, bus untouched
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_write <= head.write;
              rsp_rdata <= '0;
            end else if (head.write) begin
              mem_address_bus <= head.addr;
              wdata_q         <= head.wdata;
              mem_write_mode  <= 1'b1;
              state           <= ST_WRITE;
            end else begin
              mem_address_bus <= head.addr;
              mem_write_mode  <= 1'b0;
              state           <= ST_RD_ADDR;
            end
          end
        end
        ST_WRITE: begin
          mem_write_mode <= 1'b0;
          rsp_valid      <= 1'b1;
          rsp_write      <= 1'b1;
          rsp_err        <= 1'b0;
          rsp_rdata      <= '0;
          state          <= ST_IDLE;
        end
        ST_RD_ADDR: state <= ST_RD_DATA;
        ST_RD_DATA: begin
          rsp_valid <= 1'b1;
          rsp_write <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= mem_data_bus;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_controller.md
Name: mem_bus_controller

Overview:
- Load/store bus master sitting directly upstream of the 4-bank 4KB Memory data port; owns address_bus, the shared tri-state data_bus and write_mode.
- Accepts word read/write requests from the CPU execute stage via valid/ready, buffers them in a small FIFO and sequences them onto the memory bus.
- Returns read data, or write acknowledgements, in request order.
- Guarantees the controller never drives data_bus while the memory drives it.

Parameters:
- QUEUE_DEPTH, 2, request FIFO entries (power of 2, >=2)
- ADDR_W, 12, byte address width
- DATA_W, 16, word width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_write  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  one-cycle response pulse
- rsp_write  out  1  response belongs to a store
- rsp_err  out  1  request was misaligned (addr[0]=1)
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors
- mem_address_bus  out  ADDR_W  to Memory address_bus
- mem_data_bus  inout  DATA_W  to Memory data_bus
- mem_write_mode  out  1  to Memory write_mode
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, FIFO emptied.
  - mem_write_mode=0, mem_address_bus=0, mem_data_bus released (Z).
  - rsp_valid=0, rsp_write=0, rsp_err=0, rsp_rdata=0, busy=0.
  - req_ready=1 once rst_n=1.
- Handshake:
  - Request accepted on an edge where req_valid and req_ready are both 1.
  - req_ready=!fifo_full and is combinational from FIFO state only.
  - An accept and a pop in the same cycle on a full FIFO is not allowed; req_ready stays 0 when full.
- Bus ownership:
  - Tri-state enable of mem_data_bus is exactly the mem_write_mode register.
  - The Memory drives the bus only when write_mode=0, so there is never contention.
  - mem_* outputs are registered.
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA.
  - IDLE: if FIFO non-empty, pop the head entry.
    - Misaligned: no bus activity; next cycle rsp_valid=1, rsp_err=1, rsp_write=req type, rsp_rdata=0; stay IDLE.
    - Write: load address/data, mem_write_mode<=1, go to WRITE.
    - Read: load address, mem_write_mode<=0, go to RD_ADDR.
  - WRITE (1 cycle): bus driven; the Memory commits on the closing edge. Then mem_write_mode<=0, pulse rsp_valid with rsp_write=1, go to IDLE.
  - RD_ADDR (1 cycle): address stable; the Memory latches the word on the closing edge. Go to RD_DATA.
  - RD_DATA (1 cycle): capture mem_data_bus into rsp_rdata on the closing edge, pulse rsp_valid with rsp_write=0, go to IDLE.
- Latency:
  - Write: rsp_valid 2 cycles after the FIFO pop cycle.
  - Read: rsp_valid 3 cycles after the FIFO pop cycle.
  - Throughput: one write per 2 cycles, one read per 3 cycles. No pipelining, which also guarantees bus turnaround.
- Address handling:
  - Full 12-bit address is passed to the Memory; bank = addr[11:10], word = addr[9:1].
  - No range check; all 4096 byte addresses are valid.
- Read-after-write to the same address returns the new data (the write commits before the read address is sampled).
- FIFO boundaries:
  - Enqueue while full is blocked by req_ready=0.
  - Pop from an empty FIFO never occurs.
  - Enqueue and pop in the same cycle are both performed.
- Reset mid-operation:
  - An in-flight write commits only if rst_n is high at the committing edge.
  - All queued and in-flight requests are dropped with no response.
  - Bus is released immediately (asynchronously).

Decomposition:
- Shared package mem_bus_pkg:
  - ADDR_W/DATA_W constants.
  - Bank-select localparams (INSTR=2'b00, DATA1..DATA3).
  - Packed struct mem_req_t {write, addr, wdata}.
  - FSM state enum.
- One sub-module, req_fifo: synchronous FIFO of mem_req_t, depth QUEUE_DEPTH, with full/empty and wrap-around pointers plus an extra pointer bit.

Test Plan:
- Write then read: store addr 12'hC10, data 16'h1234; then load 12'hC10 -> write rsp_valid with rsp_write=1; read rsp_rdata=16'h1234 exactly 3 cycles after pop; mem_data_bus never X.
- Preloaded read: load 12'hFFC (data3[510]) -> rsp_rdata=16'hABCD, rsp_err=0.
- Misaligned: load 12'h401 -> mem_address_bus unchanged, rsp_valid=1 with rsp_err=1 and rsp_rdata=0 the next cycle; a following aligned load works normally.
- Backpressure: hold req_valid with 5 back-to-back reads to 12'h400..12'h408 -> req_ready drops after 2 are queued; all 5 responses arrive in order with correct data.
- Contention check: alternate write/read/write to banks 01 and 10 -> controller drive-enable and (!mem_write_mode) are never both active on the same cycle; data lands in the correct bank.
- Async reset: assert rst_n mid-RD_ADDR -> mem_write_mode=0, bus Z and rsp_valid=0 within the same cycle; no response is emitted after release; busy=0.
